transform_sequencer: RTL and testbench

TRANSFORM_SEQUENCER -- requirements
Module: transform_sequencer

---
 rtl/transform_pkg.sv | 41 ++++
 rtl/transform_sequencer.sv | 153 +++++++++++++++
 tb/tb_transform_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/transform_pkg.sv
// Shared types and field layout for the transform sequencer: FSM states,
// line-pointer and character-pair slices, and the parked ROM address.
package transform_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAP_A,
        S_MAP_B,
        S_RD_A,
        S_RD_B,
        S_OUT
    } state_t;

    localparam int START_MSB = 11;
    localparam int START_LSB = 6;
    localparam int LEN_MSB   = 5;
    localparam int LEN_LSB   = 0;
    localparam int LHS_MSB   = 15;
    localparam int LHS_LSB   = 8;
    localparam int RHS_MSB   = 7;
    localparam int RHS_LSB   = 0;

    localparam logic [7:0] IDLE_ADDR_DEFAULT = 8'hFF;

    function automatic logic [5:0] ptr_start(input logic [11:0] ptr);
        return ptr[START_MSB:START_LSB];
    endfunction

    function automatic logic [5:0] ptr_len(input logic [11:0] ptr);
        return ptr[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [7:0] dat_lhs(input logic [15:0] dat);
        return dat[LHS_MSB:LHS_LSB];
    endfunction

    function automatic logic [7:0] dat_rhs(input logic [15:0] dat);
        return dat[RHS_MSB:RHS_LSB];
    endfunction

endpackage

// File: rtl/transform_sequencer.sv
// Walks one text line: looks up its pointer in the external line mapper,
// then streams each character pair from the external ROM with a handshake.
module transform_sequencer
    import transform_pkg::*;
#(
    parameter logic [7:0] IDLE_ADDR = IDLE_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [5:0]  req_line,
    output logic        req_ready,
    input  logic        abort,
    output logic [5:0]  map_line,
    input  logic [11:0] map_addr,
    output logic [7:0]  mem_addr,
    input  logic [15:0] mem_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_lhs,
    output logic [7:0]  out_rhs,
    output logic [5:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    state_t      state_q, state_d;
    logic [5:0]  map_line_q, map_line_d;
    logic [7:0]  mem_addr_q, mem_addr_d;
    logic [5:0]  len_q, len_d;
    logic [5:0]  idx_q, idx_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_lhs_q, out_lhs_d;
    logic [7:0]  out_rhs_q, out_rhs_d;
    logic [5:0]  out_idx_q, out_idx_d;
    logic        out_last_q, out_last_d;
    logic        done_q, done_d;
    // An empty line reports completion one cycle after it returns to IDLE.
    logic        empty_pend_q, empty_pend_d;

    always_comb begin
        state_d      = state_q;
        map_line_d   = map_line_q;
        mem_addr_d   = mem_addr_q;
        len_d        = len_q;
        idx_d        = idx_q;
        out_valid_d  = out_valid_q;
        out_lhs_d    = out_lhs_q;
        out_rhs_d    = out_rhs_q;
        out_idx_d    = out_idx_q;
        out_last_d   = out_last_q;
        done_d       = empty_pend_q;
        empty_pend_d = 1'b0;

        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            mem_addr_d  = IDLE_ADDR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && !abort) begin
                        map_line_d = req_line;
                        state_d    = S_MAP_A;
                    end
                end
                S_MAP_A: state_d = S_MAP_B;
                S_MAP_B: begin
                    len_d = ptr_len(map_addr);
                    if (ptr_len(map_addr) == 6'd0) begin
                        state_d      = S_IDLE;
                        empty_pend_d = 1'b1;
                    end else begin
                        mem_addr_d = {2'b00, ptr_start(map_addr)};
                        idx_d      = 6'd0;
                        state_d    = S_RD_A;
                    end
                end
                S_RD_A: state_d = S_RD_B;
                S_RD_B: begin
                    out_lhs_d   = dat_lhs(mem_dout);
                    out_rhs_d   = dat_rhs(mem_dout);
                    out_idx_d   = idx_q;
                    out_last_d  = (idx_q == (len_q - 6'd1));
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (out_last_q) begin
                            mem_addr_d = IDLE_ADDR;
                            done_d     = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            mem_addr_d = mem_addr_q + 8'd1;
                            idx_d      = idx_q + 6'd1;
                            state_d    = S_RD_A;
                        end
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    mem_addr_d  = IDLE_ADDR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            map_line_q   <= 6'd0;
            mem_addr_q   <= IDLE_ADDR;
            len_q        <= 6'd0;
            idx_q        <= 6'd0;
            out_valid_q  <= 1'b0;
            out_lhs_q    <= 8'd0;
            out_rhs_q    <= 8'd0;
            out_idx_q    <= 6'd0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            empty_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            map_line_q   <= map_line_d;
            mem_addr_q   <= mem_addr_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            out_valid_q  <= out_valid_d;
            out_lhs_q    <= out_lhs_d;
            out_rhs_q    <= out_rhs_d;
            out_idx_q    <= out_idx_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            empty_pend_q <= empty_pend_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign map_line  = map_line_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_lhs   = out_lhs_q;
    assign out_rhs   = out_rhs_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_transform_sequencer.sv
// Directed bench for transform_sequencer with behavioural line mapper and ROM
// (both one-cycle registered), checked with immediate assertions.
module tb_transform_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [5:0]  req_line;
    logic        req_ready;
    logic        abort;
    logic [5:0]  map_line;
    logic [11:0] map_addr;
    logic [7:0]  mem_addr;
    logic [15:0] mem_dout;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_lhs;
    logic [7:0]  out_rhs;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [11:0] map_tab [0:63];
    logic [15:0] rom     [0:255];

    int passed;
    int failed;
    int total;

    transform_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_line  (req_line),
        .req_ready (req_ready),
        .abort     (abort),
        .map_line  (map_line),
        .map_addr  (map_addr),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lhs   (out_lhs),
        .out_rhs   (out_rhs),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        map_addr <= map_tab[map_line];
        mem_dout <= rom[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input int max_cycles);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        chk("wait_out_valid", {15'd0, out_valid}, 16'd1);
    endtask

    initial begin
        passed = 0;
        failed = 0;
        total  = 0;
        for (int i = 0; i < 64; i++) map_tab[i] = 12'h000;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] a8;
            a8 = a[7:0];
            rom[a] = {a8 + 8'h20, a8};
        end
        rom[3] = 16'h3174;
        rom[4] = 16'h6573;
        rom[5] = 16'h7320;
        map_tab[0] = 12'h0C3;   // start 3, len 3
        map_tab[1] = 12'h284;   // start 10, len 4
        map_tab[2] = 12'h0C0;   // start 3, len 0
        map_tab[3] = 12'hFFF;   // start 63, len 63

        rst = 1'b1; req_valid = 1'b0; req_line = 6'd0; abort = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_mem_addr", {8'd0, mem_addr}, 16'h00FF);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_map_line", {10'd0, map_line}, 16'd0);
        chk("rst_req_ready", {15'd0, req_ready}, 16'd1);
        tick();
        rst = 1'b0;
        tick();

        // Line 0: three pairs, out_ready high
        req_valid = 1'b1; req_line = 6'd0;
        tick();
        req_valid = 1'b0;
        chk("l0_busy", {15'd0, busy}, 16'd1);
        chk("l0_req_ready", {15'd0, req_ready}, 16'd0);
        tick(); tick();
        chk("l0_addr0", {8'd0, mem_addr}, 16'd3);
        tick();
        chk("l0_no_valid_e3", {15'd0, out_valid}, 16'd0);
        tick();
        chk("l0_valid_e4", {15'd0, out_valid}, 16'd1);
        chk("l0_lhs0", {8'd0, out_lhs}, 16'h31);
        chk("l0_rhs0", {8'd0, out_rhs}, 16'h74);
        chk("l0_idx0", {10'd0, out_idx}, 16'd0);
        chk("l0_last0", {15'd0, out_last}, 16'd0);
        tick();
        chk("l0_addr1", {8'd0, mem_addr}, 16'd4);
        chk("l0_valid_drop", {15'd0, out_valid}, 16'd0);
        tick(); tick();
        chk("l0_valid1", {15'd0, out_valid}, 16'd1);
        chk("l0_idx1", {10'd0, out_idx}, 16'd1);
        chk("l0_lhs1", {8'd0, out_lhs}, 16'h65);
        tick();
        chk("l0_addr2", {8'd0, mem_addr}, 16'd5);
        tick(); tick();
        chk("l0_valid2", {15'd0, out_valid}, 16'd1);
        chk("l0_lhs2", {8'd0, out_lhs}, 16'h73);
        chk("l0_rhs2", {8'd0, out_rhs}, 16'h20);
        chk("l0_idx2", {10'd0, out_idx}, 16'd2);
        chk("l0_last2", {15'd0, out_last}, 16'd1);
        chk("l0_done_early", {15'd0, done}, 16'd0);
        tick();
        chk("l0_done", {15'd0, done}, 16'd1);
        chk("l0_addr_park", {8'd0, mem_addr}, 16'h00FF);
        chk("l0_idle", {15'd0, busy}, 16'd0);
        tick();
        chk("l0_done_pulse", {15'd0, done}, 16'd0);

        // Line 2: empty line
        req_valid = 1'b1; req_line = 6'd2;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        chk("em_idle_e2", {15'd0, busy}, 16'd0);
        chk("em_done_e2", {15'd0, done}, 16'd0);
        chk("em_addr", {8'd0, mem_addr}, 16'h00FF);
        tick();
        chk("em_done_e3", {15'd0, done}, 16'd1);
        chk("em_no_valid", {15'd0, out_valid}, 16'd0);
        chk("em_req_ready", {15'd0, req_ready}, 16'd1);
        tick();
        chk("em_done_pulse", {15'd0, done}, 16'd0);

        // Line 0 with a 5-cycle stall on idx1
        req_valid = 1'b1; req_line = 6'd0;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk("st_valid1", {15'd0, out_valid}, 16'd1);
        chk("st_idx1", {10'd0, out_idx}, 16'd1);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("st_hold_valid", {15'd0, out_valid}, 16'd1);
            chk("st_hold_lhs", {8'd0, out_lhs}, 16'h65);
            chk("st_hold_rhs", {8'd0, out_rhs}, 16'h73);
            chk("st_hold_idx", {10'd0, out_idx}, 16'd1);
            chk("st_hold_addr", {8'd0, mem_addr}, 16'd4);
        end
        out_ready = 1'b1;
        tick();
        chk("st_resume_addr", {8'd0, mem_addr}, 16'd5);
        tick(); tick();
        chk("st_idx2", {10'd0, out_idx}, 16'd2);
        chk("st_last2", {15'd0, out_last}, 16'd1);
        tick();
        chk("st_done", {15'd0, done}, 16'd1);
        tick();

        // Line 1: abort during RD_B of idx1
        req_valid = 1'b1; req_line = 6'd1;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        chk("ab_addr0", {8'd0, mem_addr}, 16'd10);
        tick(); tick();
        chk("ab_lhs0", {8'd0, out_lhs}, 16'h2A);
        tick();
        chk("ab_addr1", {8'd0, mem_addr}, 16'd11);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_valid", {15'd0, out_valid}, 16'd0);
        chk("ab_busy", {15'd0, busy}, 16'd0);
        chk("ab_addr_park", {8'd0, mem_addr}, 16'h00FF);
        chk("ab_no_done", {15'd0, done}, 16'd0);
        tick();
        chk("ab_no_done2", {15'd0, done}, 16'd0);
        chk("ab_valid2", {15'd0, out_valid}, 16'd0);

        // Line 1 rerun after abort
        req_valid = 1'b1; req_line = 6'd1;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] a8;
            a8 = 8'd10 + k[7:0];
            wait_out(6);
            chk("l1_lhs", {8'd0, out_lhs}, {8'd0, a8 + 8'h20});
            chk("l1_rhs", {8'd0, out_rhs}, {8'd0, a8});
            chk("l1_idx", {10'd0, out_idx}, k[15:0]);
            chk("l1_last", {15'd0, out_last}, (k == 3) ? 16'd1 : 16'd0);
            tick();
        end
        chk("l1_done", {15'd0, done}, 16'd1);
        tick();

        // Asynchronous reset in the middle of OUT
        out_ready = 1'b0;
        req_valid = 1'b1; req_line = 6'd0;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("rs_valid_before", {15'd0, out_valid}, 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("rs_valid", {15'd0, out_valid}, 16'd0);
        chk("rs_busy", {15'd0, busy}, 16'd0);
        chk("rs_addr", {8'd0, mem_addr}, 16'h00FF);
        chk("rs_lhs", {8'd0, out_lhs}, 16'd0);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("rs_no_done", {15'd0, done}, 16'd0);
        chk("rs_idle", {15'd0, busy}, 16'd0);

        // abort together with req_valid in IDLE
        abort = 1'b1; req_valid = 1'b1; req_line = 6'd5;
        tick();
        abort = 1'b0; req_valid = 1'b0;
        chk("ai_busy", {15'd0, busy}, 16'd0);
        chk("ai_map_line", {10'd0, map_line}, 16'd0);
        chk("ai_req_ready", {15'd0, req_ready}, 16'd1);
        tick();

        // Line 3: start 63, len 63, with a stray request held during the run
        req_valid = 1'b1; req_line = 6'd3;
        tick();
        req_line = 6'd7;
        tick(); tick();
        chk("mx_addr0", {8'd0, mem_addr}, 16'd63);
        chk("mx_map_line", {10'd0, map_line}, 16'd3);
        for (int k = 0; k < 63; k++) begin
            logic [7:0] a8;
            a8 = 8'd63 + k[7:0];
            wait_out(6);
            chk("mx_idx", {10'd0, out_idx}, k[15:0]);
            chk("mx_lhs", {8'd0, out_lhs}, {8'd0, a8 + 8'h20});
            if (k == 62) begin
                chk("mx_last", {15'd0, out_last}, 16'd1);
                chk("mx_addr_last", {8'd0, mem_addr}, 16'd125);
                chk("mx_rhs_last", {8'd0, out_rhs}, 16'd125);
            end else if (k == 61) begin
                chk("mx_not_last", {15'd0, out_last}, 16'd0);
            end
            tick();
        end
        req_valid = 1'b0;
        chk("mx_done", {15'd0, done}, 16'd1);
        chk("mx_addr_park", {8'd0, mem_addr}, 16'h00FF);
        chk("mx_map_line_end", {10'd0, map_line}, 16'd3);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
